// File: rtl/mem_stage_pkg.sv
// Shared widths, load-size encodings and the EX->MEM bus layout for mem_stage.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD_DEF = 74;
    localparam int MS_TO_WS_BUS_WD_DEF = 70;
    localparam int MS_FWD_BUS_WD_DEF   = 38;

    localparam logic [1:0] LD_B = 2'b00;
    localparam logic [1:0] LD_H = 2'b01;
    localparam logic [1:0] LD_W = 2'b10;

    // Field order matches the EX->MEM bus, MSB first.
    typedef struct packed {
        logic        ld_sext;
        logic [1:0]  ld_size;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_res;
        logic [31:0] pc;
    } es_to_ms_t;

endpackage

// File: rtl/mem_load_align.sv
// Combinational load lane selection with sign/zero extension for byte, half and word loads.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  a,
    input  logic [1:0]  ld_size,
    input  logic        ld_sext,
    output logic [31:0] extracted
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = raw[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = lane[a];
    assign half_sel = a[1] ? raw[31:16] : raw[15:0];

    always_comb begin
        extracted = raw;
        case (ld_size)
            LD_B:    extracted = {{24{ld_sext & byte_sel[7]}}, byte_sel};
            LD_H:    extracted = {{16{ld_sext & half_sel[15]}}, half_sel};
            default: extracted = raw;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: merges SRAM load data with the EX result and holds read data across WB stalls.
// Optional misaligned-load detection is enabled by defining MS_UNALIGN_CHK_EN.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ES_TO_MS_BUS_WD = ES_TO_MS_BUS_WD_DEF,
    parameter int MS_TO_WS_BUS_WD = MS_TO_WS_BUS_WD_DEF,
    parameter int MS_FWD_BUS_WD   = MS_FWD_BUS_WD_DEF
)
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus,
    input  logic [31:0]                data_sram_rdata,
    output logic                       ms_ale
);

    logic        ms_valid_reg;
    logic        ms_first_reg;
    logic        buf_vld_reg;
    logic [31:0] rdata_buf_reg;
    es_to_ms_t   ms_bus_reg;

    logic        ms_ready_go;
    logic        accept;
    logic        leave;
    logic [31:0] raw;
    logic [31:0] extracted;
    logic [31:0] final_result;
    logic        gr_we_eff;

    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = !ms_valid_reg || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid_reg && ms_ready_go;
    assign accept         = es_to_ms_valid && ms_allowin;
    assign leave          = ms_to_ws_valid && ws_allowin;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_reg <= 1'b0;
            ms_first_reg <= 1'b0;
        end else begin
            if (ms_allowin) begin
                ms_valid_reg <= es_to_ms_valid;
            end
            ms_first_reg <= accept;
        end
    end

    // Bus payload is qualified by ms_valid_reg, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            ms_bus_reg <= es_to_ms_t'(es_to_ms_bus);
        end
    end

    // SRAM data is only present in the first MEM cycle; capture it if WB stalls us then.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_vld_reg <= 1'b0;
        end else if (leave || accept) begin
            buf_vld_reg <= 1'b0;
        end else if (ms_valid_reg && ms_first_reg && ms_bus_reg.res_from_mem && !ws_allowin) begin
            buf_vld_reg   <= 1'b1;
            rdata_buf_reg <= data_sram_rdata;
        end
    end

    assign raw = buf_vld_reg ? rdata_buf_reg : data_sram_rdata;

    mem_load_align u_align (
        .raw       (raw),
        .a         (ms_bus_reg.alu_res[1:0]),
        .ld_size   (ms_bus_reg.ld_size),
        .ld_sext   (ms_bus_reg.ld_sext),
        .extracted (extracted)
    );

    assign final_result = ms_bus_reg.res_from_mem ? extracted : ms_bus_reg.alu_res;

`ifdef MS_UNALIGN_CHK_EN
    assign ms_ale = ms_valid_reg && ms_bus_reg.res_from_mem &&
                    ((ms_bus_reg.ld_size == LD_H && ms_bus_reg.alu_res[0]) ||
                     (ms_bus_reg.ld_size == LD_W && ms_bus_reg.alu_res[1:0] != 2'b00));
`else
    assign ms_ale = 1'b0;
`endif

    // A misaligned load must not write the register file nor be bypassed.
    assign gr_we_eff = ms_bus_reg.gr_we && !ms_ale;

    assign ms_to_ws_bus = {gr_we_eff, ms_bus_reg.dest, final_result, ms_bus_reg.pc};
    assign ms_fwd_bus   = {ms_valid_reg && gr_we_eff, ms_bus_reg.dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Directed, table-driven bench for mem_stage plus hand-written stall and reset sequences.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [73:0] es_to_ms_bus;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [37:0] ms_fwd_bus;
    logic [31:0] data_sram_rdata;
    logic        ms_ale;

    int checks = 0;
    int errors = 0;

`ifdef MS_UNALIGN_CHK_EN
    localparam bit UNALIGN = 1'b1;
`else
    localparam bit UNALIGN = 1'b0;
`endif

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .ms_fwd_bus      (ms_fwd_bus),
        .data_sram_rdata (data_sram_rdata),
        .ms_ale          (ms_ale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        ld_sext;
        logic [1:0]  ld_size;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_res;
        logic [31:0] rdata;
        logic [31:0] exp_result;
        logic        exp_gr_we;
        logic        exp_ale;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [73:0] mk_bus(input logic sext, input logic [1:0] sz, input logic rfm,
                                           input logic we, input logic [4:0] dest,
                                           input logic [31:0] alu, input logic [31:0] pc);
        return {sext, sz, rfm, we, dest, alu, pc};
    endfunction

    logic [31:0] pc_i;

    initial begin
        // ld_sext, ld_size, res_from_mem, gr_we, dest, alu_res, rdata, exp_result, exp_gr_we, exp_ale
        vecs[0] = '{1'b1, 2'b00, 1'b1, 1'b1, 5'd5,  32'h0000_1003, 32'h8011_2233, 32'hFFFF_FF80, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 2'b01, 1'b1, 1'b1, 5'd6,  32'h0000_2002, 32'hBEEF_1234, 32'h0000_BEEF, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 2'b01, 1'b1, 1'b1, 5'd6,  32'h0000_2002, 32'hBEEF_1234, 32'hFFFF_BEEF, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 2'b10, 1'b0, 1'b1, 5'd7,  32'h0000_0042, 32'h5555_5555, 32'h0000_0042, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 2'b10, 1'b1, 1'b1, 5'd8,  32'h0000_3000, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 2'b00, 1'b1, 1'b1, 5'd9,  32'h0000_4001, 32'h1234_5678, 32'h0000_0056, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 2'b00, 1'b1, 1'b1, 5'd10, 32'h0000_4000, 32'h1234_56F0, 32'hFFFF_FFF0, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 2'b01, 1'b1, 1'b1, 5'd11, 32'h0000_5000, 32'hAAAA_7FFF, 32'h0000_7FFF, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 2'b10, 1'b1, 1'b1, 5'd12, 32'h0000_6001, 32'h89AB_CDEF, 32'h89AB_CDEF, !UNALIGN, UNALIGN};
        vecs[9] = '{1'b0, 2'b10, 1'b0, 1'b0, 5'd13, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0};

        reset = 1'b1;
        ws_allowin = 1'b1;
        es_to_ms_valid = 1'b0;
        es_to_ms_bus = '0;
        data_sram_rdata = '0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("reset_valid",   70'(ms_to_ws_valid), 70'(0));
        chk("reset_allowin", 70'(ms_allowin),     70'(1));
        chk("reset_fwd_we",  70'(ms_fwd_bus[37]), 70'(0));
        chk("reset_ale",     70'(ms_ale),         70'(0));
        next_cycle();
        reset = 1'b0;

        // Back-to-back stream: vector i is issued while vector i-1 is checked in MEM.
        for (int i = 0; i <= 10; i++) begin
            next_cycle();
            if (i < 10) begin
                pc_i = 32'h1C00_0000 + 32'(i * 4);
                es_to_ms_valid = 1'b1;
                es_to_ms_bus = mk_bus(vecs[i].ld_sext, vecs[i].ld_size, vecs[i].res_from_mem,
                                      vecs[i].gr_we, vecs[i].dest, vecs[i].alu_res, pc_i);
            end else begin
                es_to_ms_valid = 1'b0;
            end
            if (i > 0) begin
                data_sram_rdata = vecs[i-1].rdata;
                @(negedge clk);
                pc_i = 32'h1C00_0000 + 32'((i - 1) * 4);
                chk($sformatf("vec%0d_valid", i-1), 70'(ms_to_ws_valid), 70'(1));
                chk($sformatf("vec%0d_ws_bus", i-1), ms_to_ws_bus,
                    {vecs[i-1].exp_gr_we, vecs[i-1].dest, vecs[i-1].exp_result, pc_i});
                chk($sformatf("vec%0d_fwd_bus", i-1), 70'(ms_fwd_bus),
                    70'({vecs[i-1].exp_gr_we, vecs[i-1].dest, vecs[i-1].exp_result}));
                chk($sformatf("vec%0d_ale", i-1), 70'(ms_ale), 70'(vecs[i-1].exp_ale));
                $display("vec%0d: ws_bus=%h fwd=%h", i-1, ms_to_ws_bus, ms_fwd_bus);
            end
        end
        next_cycle();
        @(negedge clk);
        chk("drain_valid", 70'(ms_to_ws_valid), 70'(0));

        // Stalled lw: SRAM data changes after the first cycle, result must hold.
        next_cycle();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(1'b0, 2'b10, 1'b1, 1'b1, 5'd20, 32'h0000_7000, 32'h1C00_1000);
        next_cycle();
        es_to_ms_bus = mk_bus(1'b0, 2'b10, 1'b0, 1'b1, 5'd21, 32'h0000_0077, 32'h1C00_1004);
        ws_allowin = 1'b0;
        data_sram_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("stall0_allowin", 70'(ms_allowin), 70'(0));
        chk("stall0_bus", ms_to_ws_bus, {1'b1, 5'd20, 32'h1234_5678, 32'h1C00_1000});
        $display("stall cycle 0: ws_bus=%h", ms_to_ws_bus);
        for (int c = 1; c < 3; c++) begin
            next_cycle();
            data_sram_rdata = 32'hDEAD_DEAD;
            @(negedge clk);
            chk($sformatf("stall%0d_bus", c), ms_to_ws_bus, {1'b1, 5'd20, 32'h1234_5678, 32'h1C00_1000});
            chk($sformatf("stall%0d_fwd", c), 70'(ms_fwd_bus), 70'({1'b1, 5'd20, 32'h1234_5678}));
            $display("stall cycle %0d: ws_bus=%h", c, ms_to_ws_bus);
        end
        next_cycle();
        ws_allowin = 1'b1;
        @(negedge clk);
        chk("release_valid", 70'(ms_to_ws_valid), 70'(1));
        chk("release_bus", ms_to_ws_bus, {1'b1, 5'd20, 32'h1234_5678, 32'h1C00_1000});
        chk("release_allowin", 70'(ms_allowin), 70'(1));
        next_cycle();
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        chk("after_release_bus", ms_to_ws_bus, {1'b1, 5'd21, 32'h0000_0077, 32'h1C00_1004});
        $display("after release: ws_bus=%h", ms_to_ws_bus);

        // Reset while a stalled load (with buffered data) sits in MEM.
        next_cycle();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(1'b0, 2'b10, 1'b1, 1'b1, 5'd22, 32'h0000_8000, 32'h1C00_2000);
        next_cycle();
        es_to_ms_valid = 1'b0;
        ws_allowin = 1'b0;
        data_sram_rdata = 32'h1111_1111;
        next_cycle();
        reset = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("rst_stall_valid",   70'(ms_to_ws_valid), 70'(0));
        chk("rst_stall_allowin", 70'(ms_allowin),     70'(1));
        chk("rst_stall_fwd_we",  70'(ms_fwd_bus[37]), 70'(0));
        $display("reset mid-stall: valid=%b allowin=%b", ms_to_ws_valid, ms_allowin);
        next_cycle();
        reset = 1'b0;
        ws_allowin = 1'b1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(1'b0, 2'b10, 1'b1, 1'b1, 5'd23, 32'h0000_8000, 32'h1C00_2004);
        next_cycle();
        es_to_ms_valid = 1'b0;
        data_sram_rdata = 32'h2222_2222;
        @(negedge clk);
        chk("post_rst_bus", ms_to_ws_bus, {1'b1, 5'd23, 32'h2222_2222, 32'h1C00_2004});
        $display("post-reset load: ws_bus=%h", ms_to_ws_bus);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage in-order pipeline. It sits between exe_stage (upstream) and wb_stage (downstream).
- Accepts the EX result bus and merges the synchronous data-SRAM read data with it. Performs byte/half/word load extraction with sign/zero extension.
- Forwards the final result to WB. Also drives a bypass bus back to decode.
- Owns a one-entry read-data hold buffer, because SRAM read data is valid for exactly one cycle.

Parameters:
- ES_TO_MS_BUS_WD, 74, width of the incoming EX->MEM bus.
- MS_TO_WS_BUS_WD, 70, width of the outgoing MEM->WB bus.
- MS_FWD_BUS_WD, 38, width of the bypass bus to decode.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ws_allowin  in  1  WB can accept an instruction this cycle.
- ms_allowin  out  1  MEM can accept from EX this cycle.
- es_to_ms_valid  in  1  EX presents a valid instruction.
- es_to_ms_bus  in  ES_TO_MS_BUS_WD  fields, MSB first:
  - ld_sext 73
  - ld_size[1:0] 72:71 (00 byte, 01 half, 10 word)
  - res_from_mem 70
  - gr_we 69
  - dest 68:64
  - alu_res/address 63:32
  - pc 31:0
- ms_to_ws_valid  out  1  MEM presents a valid instruction to WB.
- ms_to_ws_bus  out  MS_TO_WS_BUS_WD  fields: {gr_we 69, dest 68:64, final_result 63:32, pc 31:0}.
- ms_fwd_bus  out  MS_FWD_BUS_WD  fields: {ms_valid&&gr_we 37, dest 36:32, final_result 31:0}.
- data_sram_rdata  in  32  read data; valid only in the cycle after EX issued the request.
- ms_ale  out  1  misaligned-load flag (see Optional Feature).

Behaviour:
- Reset: ms_valid=0, ms_first=0, buf_vld=0, bus register unchanged.
  - Outputs after reset: ms_to_ws_valid=0, ms_allowin=1, ms_fwd_bus[37]=0, ms_ale=0.
- Handshake:
  - ms_ready_go=1 (MEM never stalls itself).
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - ms_to_ws_valid = ms_valid && ms_ready_go.
- On ms_allowin: ms_valid <= es_to_ms_valid.
  - When es_to_ms_valid && ms_allowin: capture es_to_ms_bus and set ms_first<=1.
  - Otherwise ms_first<=0.
- Hold buffer:
  - Set: when ms_valid && ms_first && res_from_mem && !ws_allowin, latch data_sram_rdata into rdata_buf and set buf_vld<=1.
  - Clear: buf_vld<=0 when the instruction leaves (ms_to_ws_valid && ws_allowin).
  - Clear also applies if a new instruction is accepted in the same cycle; it has priority over set.
- Effective read data: raw = buf_vld ? rdata_buf : data_sram_rdata.
- Extraction uses a = alu_res[1:0]:
  - byte = raw[8*a+7 : 8*a]
  - half = a[1] ? raw[31:16] : raw[15:0]
  - word = raw
  - ld_sext=1 replicates the top bit of the byte/half; ld_sext=0 zero-extends. Word ignores ld_sext.
- final_result = res_from_mem ? extracted : alu_res.
- Latency: one cycle from EX acceptance to ms_to_ws_valid. Back-to-back throughput is 1 instruction/cycle when ws_allowin=1.
- Stall: while ws_allowin=0, ms_to_ws_bus and ms_fwd_bus stay stable. final_result is sourced from rdata_buf after the first cycle.
- Reset asserted mid-stall: instruction dropped, buffer invalidated next edge.

Optional Feature:
- Macro: MS_UNALIGN_CHK_EN.
- Defined:
  - ms_ale = ms_valid && res_from_mem && ((ld_size==01 && a[0]) || (ld_size==10 && a!=0)).
  - When ms_ale=1, gr_we in ms_to_ws_bus and ms_fwd_bus[37] are forced 0.
- Undefined:
  - ms_ale tied 0.
  - Low address bits are used only for lane selection; word loads ignore them.

Decomposition:
- mycpu.h holds the width macros (ES_TO_MS_BUS_WD, MS_TO_WS_BUS_WD, MS_FWD_BUS_WD), the ld_size encodings (LD_B/LD_H/LD_W) and the bus field offsets.
- One combinational sub-module, mem_load_align: inputs raw[31:0], a[1:0], ld_size, ld_sext; output extracted[31:0].

Test Plan:
- lb, addr 0x...3, ld_sext=1, rdata=0x80112233 -> final_result=0xFFFFFF80, gr_we=1, one cycle after accept.
- lhu, addr 0x...2, rdata=0xBEEF1234 -> final_result=0x0000BEEF; lh at same address -> 0xFFFFBEEF.
- lw with ws_allowin=0 for 3 cycles; rdata changes to 0xDEADDEAD after cycle 1 (original 0x12345678) -> final_result stays 0x12345678 and bus stable; passes to WB on release.
- Non-load add (res_from_mem=0, alu_res=0x00000042) back-to-back with lw -> ms_fwd_bus={1,dest,0x42}, then the load result next cycle, no bubble.
- reset asserted while a stalled load is in MEM -> next cycle ms_to_ws_valid=0, buf_vld=0, ms_allowin=1.
- With MS_UNALIGN_CHK_EN: lw at addr 0x...1 -> ms_ale=1, gr_we=0 on both buses. Without the macro -> ms_ale=0, full word returned.
